// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between the bus master and the register bank.
//   cs        chip select, active-high
//   pico_spi  serial data from master, MSB first
//   poci_spi  registered serial read data back to master
interface spi_reg_bank_if;
  logic cs;
  logic pico_spi;
  logic poci_spi;

  modport master (output cs, output pico_spi, input poci_spi);
  modport slave  (input cs, input pico_spi, output poci_spi);
endinterface

// File: rtl/spi_reg_bank.sv
// SPI-slave configuration register bank.
// Deserialises a (R/W, address) header followed by data words and stores
// NUM_REGS registers of DATA_WIDTH bits at addresses 1..NUM_REGS.
// Supports burst auto-increment, read-only and self-clearing register masks,
// per-register write strobes and a sticky framing-error flag.
//   spi_clk    sole clock, rising edge
//   rst        synchronous active-high reset
//   bus        SPI pins (cs, pico_spi in; poci_spi out)
//   reg_out    packed register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_strobe  one-cycle pulse per register after a committed write
//   frame_err  sticky, set when cs drops mid-word
module spi_reg_bank #(
  parameter int NUM_REGS   = 11,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RST_VALS = '0,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0] PULSE_MASK = NUM_REGS'('b100),
  parameter bit AUTO_INC = 1'b1
) (
  input  logic                           spi_clk,
  input  logic                           rst,
  spi_reg_bank_if.slave                  bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_strobe,
  output logic                           frame_err
);

  localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    rw;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-2:0]   data_sr;
  logic [DATA_WIDTH-1:0]   shadow;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

  logic                    hdr_done, word_done;
  logic [ADDR_WIDTH-1:0]   hdr_addr, addr_inc, rd_addr;
  logic [DATA_WIDTH-1:0]   word_nxt, rd_word;
  logic [NUM_REGS-1:0]     commit;

  // Out-of-range addresses (including 0) read as zero.
  function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [ADDR_WIDTH-1:0] a);
    read_reg = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == ADDR_WIDTH'(i + 1)) read_reg = regs[i];
  endfunction

  // One-hot write select; read-only and out-of-range targets select nothing.
  function automatic logic [NUM_REGS-1:0] write_sel(input logic [ADDR_WIDTH-1:0] a);
    write_sel = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == ADDR_WIDTH'(i + 1) && !RO_MASK[i]) write_sel[i] = 1'b1;
  endfunction

  always_comb begin
    hdr_done  = (state == HEADER) && bus.cs && (cnt == CNT_W'(ADDR_WIDTH));
    word_done = (state == DATA) && bus.cs && (cnt == CNT_W'(DATA_WIDTH - 1));
    hdr_addr  = {addr[ADDR_WIDTH-2:0], bus.pico_spi};
    word_nxt  = {data_sr, bus.pico_spi};
    addr_inc  = AUTO_INC ? addr + ADDR_WIDTH'(1) : addr;
    // Shadow reloads from the address that becomes current after this edge.
    rd_addr   = hdr_done ? hdr_addr : addr_inc;
    rd_word   = read_reg(rd_addr);
    commit    = (word_done && rw) ? write_sel(addr) : '0;
  end

  always_comb begin
    state_nxt = state;
    if (!bus.cs) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = HEADER;
        HEADER:  if (cnt == CNT_W'(ADDR_WIDTH)) state_nxt = DATA;
        DATA:    state_nxt = DATA;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge spi_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge spi_clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VALS[i*DATA_WIDTH +: DATA_WIDTH];
      cnt          <= '0;
      bus.poci_spi <= 1'b0;
      wr_strobe    <= '0;
      frame_err    <= 1'b0;
    end else begin
      wr_strobe <= commit;
      if (!bus.cs) begin
        cnt          <= '0;
        bus.poci_spi <= 1'b0;
        if (state != IDLE) begin
          // Partial header or partial word counts as a framing error.
          if (cnt != '0) frame_err <= 1'b1;
          for (int i = 0; i < NUM_REGS; i++)
            if (PULSE_MASK[i]) regs[i] <= RST_VALS[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end else begin
        case (state)
          IDLE: begin
            // This edge samples the R/W bit.
            rw           <= bus.pico_spi;
            addr         <= '0;
            cnt          <= CNT_W'(1);
            frame_err    <= 1'b0;
            bus.poci_spi <= 1'b0;
          end
          HEADER: begin
            addr <= hdr_addr;
            if (hdr_done) begin
              cnt          <= '0;
              bus.poci_spi <= rd_word[DATA_WIDTH-1];
              shadow       <= {rd_word[DATA_WIDTH-2:0], 1'b0};
            end else begin
              cnt          <= cnt + CNT_W'(1);
              bus.poci_spi <= 1'b0;
            end
          end
          DATA: begin
            data_sr <= word_nxt[DATA_WIDTH-2:0];
            if (word_done) begin
              cnt  <= '0;
              addr <= addr_inc;
              for (int i = 0; i < NUM_REGS; i++)
                if (commit[i]) regs[i] <= word_nxt;
              bus.poci_spi <= rd_word[DATA_WIDTH-1];
              shadow       <= {rd_word[DATA_WIDTH-2:0], 1'b0};
            end else begin
              cnt          <= cnt + CNT_W'(1);
              bus.poci_spi <= shadow[DATA_WIDTH-1];
              shadow       <= {shadow[DATA_WIDTH-2:0], 1'b0};
            end
          end
          default: bus.poci_spi <= 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
module tb_spi_reg_bank;

  localparam int NR = 11;
  localparam int DW = 8;
  localparam int AW = 7;
  localparam logic [NR*DW-1:0] RST = {8'h3A, 8'h39, 8'h38, 8'h37, 8'h36, 8'h35,
                                      8'h34, 8'h33, 8'h32, 8'h31, 8'h30};
  localparam logic [NR-1:0] RO    = 11'b000_0001_0000;  // address 5
  localparam logic [NR-1:0] PULSE = 11'b000_0000_0100;  // address 3

  logic spi_clk = 1'b0;
  logic rst     = 1'b1;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]    wr_strobe;
  logic             frame_err;

  spi_reg_bank_if bus ();

  spi_reg_bank #(
    .NUM_REGS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .RST_VALS(RST), .RO_MASK(RO), .PULSE_MASK(PULSE), .AUTO_INC(1'b1)
  ) dut (
    .spi_clk(spi_clk), .rst(rst), .bus(bus),
    .reg_out(reg_out), .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  always #5 spi_clk = ~spi_clk;

  int vecs = 0;
  int errs = 0;
  logic [NR*DW-1:0] exp_out;
  logic [DW-1:0] rx;

  // Drive one bit, then return 1 time unit after the sampling edge.
  task automatic clk_bit(input logic c, input logic b);
    @(negedge spi_clk);
    bus.cs = c;
    bus.pico_spi = b;
    @(posedge spi_clk);
    #1;
  endtask

  task automatic send_header(input logic w, input logic [AW-1:0] a);
    clk_bit(1'b1, w);
    for (int i = AW - 1; i >= 0; i--) clk_bit(1'b1, a[i]);
  endtask

  // poci_spi before each data edge carries the read bit of the same index.
  task automatic send_word(input logic [DW-1:0] d, output logic [DW-1:0] r);
    for (int i = DW - 1; i >= 0; i--) begin
      r[i] = bus.poci_spi;
      clk_bit(1'b1, d[i]);
    end
  endtask

  task automatic end_frame();
    clk_bit(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    bus.cs = 1'b0; bus.pico_spi = 1'b0; rst = 1'b1;
    repeat (2) @(posedge spi_clk);
    #1;
    if (reg_out !== RST) begin errs++; $display("FAIL reset_regs got %h want %h", reg_out, RST); end
    vecs++;
    if (bus.poci_spi !== 1'b0) begin errs++; $display("FAIL reset_poci got %b want 0", bus.poci_spi); end
    vecs++;
    if (frame_err !== 1'b0) begin errs++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    vecs++;
    if (wr_strobe !== '0) begin errs++; $display("FAIL reset_strobe got %b want 0", wr_strobe); end
    vecs++;
    @(negedge spi_clk);
    rst = 1'b0;
    exp_out = RST;
  endtask

  task automatic test_single_write();
    send_header(1'b1, 7'd2);
    send_word(8'hA5, rx);
    exp_out[1*DW +: DW] = 8'hA5;
    if (rx !== 8'h31) begin errs++; $display("FAIL sw_echo got %h want 31", rx); end
    vecs++;
    if (reg_out !== exp_out) begin errs++; $display("FAIL sw_regs got %h want %h", reg_out, exp_out); end
    vecs++;
    if (wr_strobe !== 11'b000_0000_0010) begin errs++; $display("FAIL sw_strobe got %b want 00000000010", wr_strobe); end
    vecs++;
    end_frame();
    if (wr_strobe !== '0) begin errs++; $display("FAIL sw_strobe_off got %b want 0", wr_strobe); end
    vecs++;
  endtask

  // Burst at address 6 (clear of the pulse register at address 3).
  task automatic test_burst();
    logic [DW-1:0] wdat [3];
    logic [DW-1:0] echo [3];
    wdat = '{8'h11, 8'h22, 8'h33};
    echo = '{8'h35, 8'h36, 8'h37};
    send_header(1'b1, 7'd6);
    for (int k = 0; k < 3; k++) begin
      send_word(wdat[k], rx);
      exp_out[(5 + k)*DW +: DW] = wdat[k];
      if (rx !== echo[k]) begin errs++; $display("FAIL bw_echo%0d got %h want %h", k, rx, echo[k]); end
      vecs++;
      if (wr_strobe !== NR'(1) << (5 + k)) begin errs++; $display("FAIL bw_strobe%0d got %b", k, wr_strobe); end
      vecs++;
    end
    end_frame();
    if (reg_out !== exp_out) begin errs++; $display("FAIL bw_regs got %h want %h", reg_out, exp_out); end
    vecs++;
    send_header(1'b0, 7'd6);
    if (bus.poci_spi !== 1'b0) begin errs++; $display("FAIL br_first_bit got %b want 0", bus.poci_spi); end
    vecs++;
    for (int k = 0; k < 3; k++) begin
      send_word(8'hFF, rx);
      if (rx !== wdat[k]) begin errs++; $display("FAIL br_word%0d got %h want %h", k, rx, wdat[k]); end
      vecs++;
      if (wr_strobe !== '0) begin errs++; $display("FAIL br_strobe%0d got %b want 0", k, wr_strobe); end
      vecs++;
    end
    end_frame();
    if (reg_out !== exp_out) begin errs++; $display("FAIL br_regs got %h want %h", reg_out, exp_out); end
    vecs++;
  endtask

  task automatic test_boundary();
    send_header(1'b1, 7'd11);
    send_word(8'h77, rx);
    exp_out[10*DW +: DW] = 8'h77;
    if (rx !== 8'h3A) begin errs++; $display("FAIL bd_echo got %h want 3a", rx); end
    vecs++;
    if (wr_strobe !== 11'b100_0000_0000) begin errs++; $display("FAIL bd_strobe got %b want 10000000000", wr_strobe); end
    vecs++;
    send_word(8'h88, rx);
    if (rx !== 8'h00) begin errs++; $display("FAIL bd_oor_read got %h want 00", rx); end
    vecs++;
    if (wr_strobe !== '0) begin errs++; $display("FAIL bd_oor_strobe got %b want 0", wr_strobe); end
    vecs++;
    end_frame();
    if (reg_out !== exp_out) begin errs++; $display("FAIL bd_regs got %h want %h", reg_out, exp_out); end
    vecs++;
    send_header(1'b0, 7'd0);
    send_word(8'h00, rx);
    if (rx !== 8'h00) begin errs++; $display("FAIL bd_addr0 got %h want 00", rx); end
    vecs++;
    end_frame();
  endtask

  task automatic test_masks();
    send_header(1'b1, 7'd5);
    send_word(8'hEE, rx);
    if (rx !== 8'h34) begin errs++; $display("FAIL ro_echo got %h want 34", rx); end
    vecs++;
    if (wr_strobe !== '0) begin errs++; $display("FAIL ro_strobe got %b want 0", wr_strobe); end
    vecs++;
    if (reg_out !== exp_out) begin errs++; $display("FAIL ro_regs got %h want %h", reg_out, exp_out); end
    vecs++;
    end_frame();
    send_header(1'b1, 7'd3);
    send_word(8'h02, rx);
    if (reg_out[2*DW +: DW] !== 8'h02) begin errs++; $display("FAIL pulse_in_frame got %h want 02", reg_out[2*DW +: DW]); end
    vecs++;
    if (wr_strobe !== 11'b000_0000_0100) begin errs++; $display("FAIL pulse_strobe got %b want 00000000100", wr_strobe); end
    vecs++;
    end_frame();
    if (reg_out !== exp_out) begin errs++; $display("FAIL pulse_cleared got %h want %h", reg_out, exp_out); end
    vecs++;
  endtask

  task automatic test_abort();
    send_header(1'b1, 7'd7);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, 1'b1);
    end_frame();
    if (frame_err !== 1'b1) begin errs++; $display("FAIL ab_ferr_set got %b want 1", frame_err); end
    vecs++;
    if (reg_out !== exp_out) begin errs++; $display("FAIL ab_no_commit got %h want %h", reg_out, exp_out); end
    vecs++;
    clk_bit(1'b1, 1'b1);
    if (frame_err !== 1'b0) begin errs++; $display("FAIL ab_ferr_clear got %b want 0", frame_err); end
    vecs++;
    for (int i = AW - 1; i >= 0; i--) clk_bit(1'b1, i < 3);
    clk_bit(1'b1, 1'b0);
    clk_bit(1'b1, 1'b1);
    @(negedge spi_clk);
    rst = 1'b1;
    clk_bit(1'b1, 1'b0);
    if (reg_out !== RST) begin errs++; $display("FAIL ab_rst_regs got %h want %h", reg_out, RST); end
    vecs++;
    if (bus.poci_spi !== 1'b0) begin errs++; $display("FAIL ab_rst_poci got %b want 0", bus.poci_spi); end
    vecs++;
    if (frame_err !== 1'b0) begin errs++; $display("FAIL ab_rst_ferr got %b want 0", frame_err); end
    vecs++;
    @(negedge spi_clk);
    rst = 1'b0;
    end_frame();
    exp_out = RST;
    // A fresh write after the mid-frame reset must work normally.
    send_header(1'b1, 7'd1);
    send_word(8'h5A, rx);
    exp_out[0 +: DW] = 8'h5A;
    if (reg_out !== exp_out) begin errs++; $display("FAIL ab_after_rst got %h want %h", reg_out, exp_out); end
    vecs++;
    end_frame();
  endtask

  initial begin
    bus.cs = 1'b0;
    bus.pico_spi = 1'b0;
    test_reset();
    test_single_write();
    test_burst();
    test_boundary();
    test_masks();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
